// File: rtl/avalon_burst_mem_slave.sv
// Avalon-MM burst memory slave with configurable stall and read latency.
// One command is in flight at a time; write bursts finish before any read is taken.
module avalon_burst_mem_slave #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MEM_WORDS    = 256,
    parameter int WAIT_CYCLES  = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [AW-1:0]     s_av_address_i,
    input  logic [DW/8-1:0]   s_av_byteenable_i,
    input  logic              s_av_read_i,
    output logic [DW-1:0]     s_av_readdata_o,
    input  logic [7:0]        s_av_burstcount_i,
    input  logic              s_av_write_i,
    input  logic [DW-1:0]     s_av_writedata_i,
    output logic              s_av_waitrequest_o,
    output logic              s_av_readdatavalid_o,
    output logic              err_o
);

    localparam int BW  = DW / 8;
    localparam int BSH = $clog2(BW);
    localparam int IW  = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, STALL, WR_BURST, RD_LAT, RD_BURST} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [MEM_WORDS];
    logic [IW-1:0] idx, idx_nxt;
    logic [7:0]    beats, beats_nxt;
    logic [3:0]    stall_cnt, stall_cnt_nxt;
    logic [2:0]    lat_cnt, lat_cnt_nxt;
    logic [DW-1:0] readdata;
    logic          err, err_nxt;
    logic          mem_we;
    logic [IW-1:0] mem_widx;
    logic          rd_load;
    logic [IW-1:0] rd_lidx;
    logic          waitrequest;
    logic          accept;
    logic [IW-1:0] cmd_idx;
    logic [7:0]    cmd_beats;
    logic          unused_addr;

    assign cmd_idx     = s_av_address_i[BSH +: IW];
    assign cmd_beats   = (s_av_burstcount_i == 8'd0) ? 8'd1 : s_av_burstcount_i;
    assign unused_addr = ^s_av_address_i;

    // idx always points at the next word to write or to fetch for a read beat
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        beats_nxt     = beats;
        stall_cnt_nxt = stall_cnt;
        lat_cnt_nxt   = lat_cnt;
        err_nxt       = err;
        mem_we        = 1'b0;
        mem_widx      = idx;
        rd_load       = 1'b0;
        rd_lidx       = idx;
        waitrequest   = 1'b0;
        accept        = 1'b0;

        case (state)
            IDLE: begin
                waitrequest = (WAIT_CYCLES != 0);
                if (s_av_read_i || s_av_write_i) begin
                    if (WAIT_CYCLES == 0) begin
                        accept = 1'b1;
                    end else begin
                        state_nxt     = STALL;
                        stall_cnt_nxt = 4'd1;
                    end
                end
            end
            STALL: begin
                waitrequest = 1'b1;
                if (!(s_av_read_i || s_av_write_i)) begin
                    state_nxt = IDLE;
                end else if (int'(stall_cnt) < WAIT_CYCLES) begin
                    stall_cnt_nxt = stall_cnt + 4'd1;
                end else begin
                    waitrequest = 1'b0;
                    accept      = 1'b1;
                end
            end
            WR_BURST: begin
                if (s_av_read_i) begin
                    err_nxt = 1'b1;
                end
                if (s_av_write_i) begin
                    mem_we    = 1'b1;
                    mem_widx  = idx;
                    idx_nxt   = idx + IW'(1);
                    beats_nxt = beats - 8'd1;
                    if (beats == 8'd1) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RD_LAT: begin
                waitrequest = 1'b1;
                if (int'(lat_cnt) >= READ_LATENCY - 1) begin
                    state_nxt = RD_BURST;
                    rd_load   = 1'b1;
                    rd_lidx   = idx;
                    idx_nxt   = idx + IW'(1);
                end else begin
                    lat_cnt_nxt = lat_cnt + 3'd1;
                end
            end
            RD_BURST: begin
                waitrequest = 1'b1;
                if (beats == 8'd1) begin
                    state_nxt = IDLE;
                end else begin
                    beats_nxt = beats - 8'd1;
                    rd_load   = 1'b1;
                    rd_lidx   = idx;
                    idx_nxt   = idx + IW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A simultaneous read and write is served as a write and flagged
        if (accept) begin
            if (s_av_write_i) begin
                mem_we    = 1'b1;
                mem_widx  = cmd_idx;
                idx_nxt   = cmd_idx + IW'(1);
                beats_nxt = cmd_beats - 8'd1;
                if (s_av_read_i) begin
                    err_nxt = 1'b1;
                end
                state_nxt = (cmd_beats > 8'd1) ? WR_BURST : IDLE;
            end else begin
                beats_nxt = cmd_beats;
                if (READ_LATENCY <= 1) begin
                    state_nxt = RD_BURST;
                    rd_load   = 1'b1;
                    rd_lidx   = cmd_idx;
                    idx_nxt   = cmd_idx + IW'(1);
                end else begin
                    state_nxt   = RD_LAT;
                    idx_nxt     = cmd_idx;
                    lat_cnt_nxt = 3'd1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state     <= IDLE;
            idx       <= '0;
            beats     <= '0;
            stall_cnt <= '0;
            lat_cnt   <= '0;
            err       <= 1'b0;
            readdata  <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            beats     <= beats_nxt;
            stall_cnt <= stall_cnt_nxt;
            lat_cnt   <= lat_cnt_nxt;
            err       <= err_nxt;
            if (rd_load) begin
                readdata <= mem[rd_lidx];
            end
        end
    end

    // Storage is never cleared; a reset cycle simply blocks the write
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_n_i && mem_we) begin
            for (int b = 0; b < BW; b++) begin
                if (s_av_byteenable_i[b]) begin
                    mem[mem_widx][8*b +: 8] <= s_av_writedata_i[8*b +: 8];
                end
            end
        end
    end

    assign s_av_readdata_o      = readdata;
    assign s_av_readdatavalid_o = (state == RD_BURST);
    assign s_av_waitrequest_o   = waitrequest;
    assign err_o                = err;

endmodule

// File: tb/tb_avalon_burst_mem_slave.sv
// Self-checking bench: a fast slave (no stall, latency 1) and a slow slave (3 stall, latency 4)
// driven with directed and random bursts, checked against a word-array memory model.
module tb_avalon_burst_mem_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN       [2];
    logic [31:0] address    [2];
    logic [3:0]  byteEn     [2];
    logic        rd         [2];
    logic        wr         [2];
    logic [7:0]  burstCount [2];
    logic [31:0] wdata      [2];
    logic [31:0] rdata      [2];
    logic        waitReq    [2];
    logic        rdValid    [2];
    logic        errFlag    [2];

    logic [31:0] modelMem [2][256];
    bit          modelErr [2];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] lastWord;
    int          quiet;

    avalon_burst_mem_slave #(
        .AW(32), .DW(32), .MEM_WORDS(256), .WAIT_CYCLES(0), .READ_LATENCY(1)
    ) dutFast (
        .wb_clk_i(clk), .wb_rst_n_i(rstN[0]),
        .s_av_address_i(address[0]), .s_av_byteenable_i(byteEn[0]),
        .s_av_read_i(rd[0]), .s_av_readdata_o(rdata[0]),
        .s_av_burstcount_i(burstCount[0]), .s_av_write_i(wr[0]),
        .s_av_writedata_i(wdata[0]), .s_av_waitrequest_o(waitReq[0]),
        .s_av_readdatavalid_o(rdValid[0]), .err_o(errFlag[0])
    );

    avalon_burst_mem_slave #(
        .AW(32), .DW(32), .MEM_WORDS(256), .WAIT_CYCLES(3), .READ_LATENCY(4)
    ) dutSlow (
        .wb_clk_i(clk), .wb_rst_n_i(rstN[1]),
        .s_av_address_i(address[1]), .s_av_byteenable_i(byteEn[1]),
        .s_av_read_i(rd[1]), .s_av_readdata_o(rdata[1]),
        .s_av_burstcount_i(burstCount[1]), .s_av_write_i(wr[1]),
        .s_av_writedata_i(wdata[1]), .s_av_waitrequest_o(waitReq[1]),
        .s_av_readdatavalid_o(rdValid[1]), .err_o(errFlag[1])
    );

    function automatic int waitsOf(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int wordIndex(input logic [31:0] byteAddr);
        return int'((byteAddr / 4) % 256);
    endfunction

    function automatic void applyModel(input int d, input int idx, input logic [31:0] data, input logic [3:0] en);
        for (int b = 0; b < 4; b++) begin
            if (en[b]) modelMem[d][idx][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Holds off until waitrequest is seen low; stall counts the high cycles first
    task automatic waitAccept(input int d, output int stall);
        stall = 0;
        #1;
        while (waitReq[d] && stall < 40) begin
            stall++;
            @(negedge clk); #1;
        end
        if (stall >= 40) checkOutput("accept_timeout", 1, 0);
    endtask

    // immediate=1 drops reset in the current cycle so an ongoing burst is cut short
    task automatic applyReset(input int d, input bit immediate);
        if (!immediate) @(negedge clk);
        rstN[d] = 1'b0;
        @(negedge clk);
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        #1;
        checkOutput("rst_valid", rdValid[d], 0);
        checkOutput("rst_err", errFlag[d], 0);
        checkOutput("rst_rdata", rdata[d], 0);
        @(negedge clk);
        rstN[d] = 1'b1;
        #1;
        checkOutput("rst_wait", waitReq[d], waitsOf(d) != 0);
        modelErr[d] = 1'b0;
    endtask

    task automatic busWrite(input int d, input logic [31:0] byteAddr, input logic [7:0] countField,
                            input bit randData, input logic [31:0] data0, input logic [3:0] en0,
                            input bit gaps, input bit withRead, input bit readMid, input int abortAt);
        int beats;
        int idx;
        int stall;
        int gapN;
        logic [31:0] data;
        logic [3:0]  en;
        beats = (countField == 8'd0) ? 1 : int'(countField);
        idx   = wordIndex(byteAddr);
        @(negedge clk);
        data = randData ? $urandom : data0;
        en   = randData ? 4'($urandom) : en0;
        address[d] = byteAddr; burstCount[d] = countField;
        wdata[d] = data; byteEn[d] = en; wr[d] = 1'b1; rd[d] = withRead;
        waitAccept(d, stall);
        checkOutput("wr_stall", stall, waitsOf(d));
        applyModel(d, idx, data, en);
        idx = (idx + 1) % 256;
        if (withRead) modelErr[d] = 1'b1;
        for (int b = 1; b < beats; b++) begin
            @(negedge clk);
            wr[d] = 1'b0; rd[d] = 1'b0;
            address[d] = $urandom; burstCount[d] = 8'($urandom);
            gapN = 0;
            while (gaps && gapN < 3 && $urandom_range(0, 2) == 0) begin
                gapN++;
                if (readMid) begin rd[d] = 1'b1; modelErr[d] = 1'b1; end
                @(negedge clk);
                rd[d] = 1'b0;
            end
            data = randData ? $urandom : data0 + 32'(b);
            en   = randData ? 4'($urandom) : en0;
            wdata[d] = data; byteEn[d] = en; wr[d] = 1'b1;
            if (b == abortAt) begin
                applyReset(d, 1'b1);
                return;
            end
            if (readMid && b == 1) begin rd[d] = 1'b1; modelErr[d] = 1'b1; end
            #1 checkOutput("wr_beat_wait", waitReq[d], 0);
            applyModel(d, idx, data, en);
            idx = (idx + 1) % 256;
        end
        @(negedge clk);
        wr[d] = 1'b0; rd[d] = 1'b0;
        #1 checkOutput("wr_err", errFlag[d], modelErr[d]);
    endtask

    // abortAfter>0 resets the slave once that many beats have been delivered
    task automatic busRead(input int d, input logic [31:0] byteAddr, input logic [7:0] countField,
                           input int abortAfter, output logic [31:0] lastData);
        int beats;
        int idx;
        int stall;
        int lat;
        int extra;
        logic [31:0] lastExp;
        beats    = (countField == 8'd0) ? 1 : int'(countField);
        idx      = wordIndex(byteAddr);
        lastData = '0;
        lastExp  = '0;
        @(negedge clk);
        address[d] = byteAddr; burstCount[d] = countField; rd[d] = 1'b1; wr[d] = 1'b0;
        waitAccept(d, stall);
        checkOutput("rd_stall", stall, waitsOf(d));
        @(negedge clk);
        rd[d] = 1'b0; address[d] = $urandom;
        #1 checkOutput("rd_busy", waitReq[d], 1);
        lat = 1;
        while (!rdValid[d] && lat < 20) begin
            @(negedge clk); #1;
            lat++;
        end
        checkOutput("rd_latency", lat, latOf(d));
        for (int b = 0; b < beats; b++) begin
            checkOutput("rd_valid", rdValid[d], 1);
            checkOutput("rd_data", rdata[d], modelMem[d][idx]);
            lastData = rdata[d];
            lastExp  = modelMem[d][idx];
            idx = (idx + 1) % 256;
            if (b == abortAfter - 1) begin
                applyReset(d, 1'b1);
                extra = 0;
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk); #1;
                    if (rdValid[d]) extra++;
                end
                checkOutput("abort_no_valid", extra, 0);
                return;
            end
            @(negedge clk); #1;
        end
        checkOutput("rd_valid_end", rdValid[d], 0);
        checkOutput("rd_hold", rdata[d], lastExp);
        checkOutput("rd_idle_wait", waitReq[d], waitsOf(d) != 0);
        checkOutput("rd_err", errFlag[d], modelErr[d]);
    endtask

    // Stimulus sequence: fill memory, directed corner cases, then random traffic
    task automatic applyStimulus(input int d);
        logic [31:0] addr;
        logic [31:0] seed;
        busWrite(d, 32'h0, 8'd128, 1'b0, $urandom, 4'hF, 1'b0, 1'b0, 1'b0, -1);
        busWrite(d, 32'h200, 8'd128, 1'b0, $urandom, 4'hF, 1'b0, 1'b0, 1'b0, -1);

        busWrite(d, 32'h10, 8'd1, 1'b0, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, -1);
        busRead(d, 32'h10, 8'd1, -1, lastWord);
        checkOutput("write_then_read", lastWord, 32'hDEADBEEF);

        busWrite(d, 32'h3F8, 8'd4, 1'b0, 32'd1, 4'hF, 1'b1, 1'b0, 1'b0, -1);
        busRead(d, 32'h3F8, 8'd4, -1, lastWord);
        checkOutput("wrap_last_beat", lastWord, 32'd4);

        busWrite(d, 32'h0, 8'd1, 1'b0, 32'h11223344, 4'hF, 1'b0, 1'b0, 1'b0, -1);
        busWrite(d, 32'h0, 8'd1, 1'b0, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 1'b0, -1);
        busRead(d, 32'h0, 8'd1, -1, lastWord);
        checkOutput("byteenable_merge", lastWord, 32'h11BB33DD);

        busWrite(d, 32'h40, 8'd0, 1'b0, 32'hCAFE0001, 4'hF, 1'b0, 1'b0, 1'b0, -1);
        busRead(d, 32'h40, 8'd0, -1, lastWord);
        checkOutput("burstcount_zero", lastWord, 32'hCAFE0001);

        busRead(d, 32'h20, 8'd2, -1, lastWord);

        busWrite(d, 32'h1C0, 8'd8, 1'b1, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, -1);
        busRead(d, 32'h1C0, 8'd8, 3, lastWord);
        busRead(d, 32'h1C0, 8'd8, -1, lastWord);

        busWrite(d, 32'h100, 8'd6, 1'b1, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3);
        busRead(d, 32'h100, 8'd6, -1, lastWord);

        seed = $urandom;
        busWrite(d, 32'h80, 8'd1, 1'b0, seed, 4'hF, 1'b0, 1'b1, 1'b0, -1);
        quiet = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (rdValid[d]) quiet++;
        end
        checkOutput("both_cmd_no_valid", quiet, 0);
        busRead(d, 32'h80, 8'd1, -1, lastWord);
        checkOutput("both_cmd_write_done", lastWord, seed);
        busWrite(d, 32'h300, 8'd5, 1'b1, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, -1);
        checkOutput("err_sticky", errFlag[d], 1);
        applyReset(d, 1'b0);

        busWrite(d, 32'h300, 8'd5, 1'b1, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, -1);
        busRead(d, 32'h300, 8'd5, -1, lastWord);
        applyReset(d, 1'b0);

        for (int n = 0; n < 25; n++) begin
            addr = $urandom;
            if ($urandom_range(0, 1) == 1)
                busWrite(d, addr, 8'($urandom_range(0, 9)), 1'b1, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, -1);
            else
                busRead(d, addr, 8'($urandom_range(0, 9)), -1, lastWord);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstN[d] = 1'b0; address[d] = '0; byteEn[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
            burstCount[d] = '0; wdata[d] = '0; modelErr[d] = 1'b0;
        end
        applyReset(0, 1'b0);
        applyReset(1, 1'b0);
        applyStimulus(0);
        applyStimulus(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_burst_mem_slave.md
AVALON_BURST_MEM_SLAVE -- requirements
Module: avalon_burst_mem_slave

Interface
REQ-001 SHALL have parameter AW, default 32, meaning Avalon byte-address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width (8, 16, 32 or 64).
REQ-003 SHALL have parameter MEM_WORDS, default 256, meaning memory depth in DW-bit words (power of 2).
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, meaning waitrequest stall cycles before a command is accepted (0..7).
REQ-005 SHALL have parameter READ_LATENCY, default 1, meaning cycles from read accept to first readdatavalid (1..4).
REQ-006 SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-007 SHALL have port wb_clk_i, input, 1, meaning the sole clock; all state updates on its rising edge.
REQ-008 SHALL have port wb_rst_n_i, input, 1, meaning the synchronous active-low reset.
REQ-009 SHALL have port s_av_address_i, input, AW, meaning the byte address of the first burst beat.
REQ-010 SHALL have port s_av_byteenable_i, input, DW/8, meaning the per-byte write enables.
REQ-011 SHALL have port s_av_read_i, input, 1, meaning the read command.
REQ-012 SHALL have port s_av_readdata_o, output, DW, meaning the read data.
REQ-013 SHALL have port s_av_burstcount_i, input, 8, meaning the beats in the burst.
REQ-014 SHALL have port s_av_write_i, input, 1, meaning the write command or write beat.
REQ-015 SHALL have port s_av_writedata_i, input, DW, meaning the write data.
REQ-016 SHALL have port s_av_waitrequest_o, output, 1, meaning the slave stall.
REQ-017 SHALL have port s_av_readdatavalid_o, output, 1, meaning s_av_readdata_o is valid this cycle.
REQ-018 SHALL have port err_o, output, 1, meaning a sticky protocol-error flag.

Function
REQ-019 SHALL compute word index = (address >> log2(DW/8)) mod MEM_WORDS; successive beats SHALL use index+1, wrapping from MEM_WORDS-1 to 0.
REQ-020 SHALL treat burstcount 0 as 1.
REQ-021 SHALL implement FSM states IDLE, STALL, WR_BURST, RD_LAT, RD_BURST.
REQ-022 In IDLE with read or write high: if WAIT_CYCLES=0, SHALL accept the command in the same cycle with waitrequest low; otherwise SHALL go to STALL with waitrequest high.
REQ-023 In STALL, waitrequest SHALL stay high for exactly WAIT_CYCLES cycles, then drop for one cycle, in which the command is accepted.
REQ-024 In IDLE and STALL with no command, waitrequest SHALL be high when WAIT_CYCLES>0 and low when WAIT_CYCLES=0.
REQ-025 A write accept SHALL store beat 0, latch the address and count, and go to WR_BURST if count>1, else to IDLE.
REQ-026 In WR_BURST, waitrequest SHALL be low; each cycle with write high SHALL store one beat; after the last beat the FSM SHALL return to IDLE.
REQ-027 In WR_BURST, cycles with write low SHALL be idle beats that store nothing and do not advance the count.
REQ-028 A write beat SHALL update only the bytes whose byteenable bit is 1.
REQ-029 A read accept SHALL latch the address and count and go to RD_LAT; waitrequest SHALL be high from the cycle after accept until the FSM returns to IDLE.
REQ-030 RD_LAT SHALL last READ_LATENCY-1 cycles, so the first readdatavalid occurs READ_LATENCY cycles after accept.
REQ-031 RD_BURST SHALL assert readdatavalid on consecutive cycles, one beat per cycle, for exactly count beats, then return to IDLE.
REQ-032 s_av_readdata_o SHALL hold its last value when readdatavalid is low.
REQ-033 read and write both high at accept SHALL be a protocol error: the write SHALL be performed, the read ignored, and err_o set.
REQ-034 A read asserted during WR_BURST SHALL be a protocol error: err_o SHALL be set and the read ignored.
REQ-035 Once set, err_o SHALL stay high until reset.
REQ-036 A write burst SHALL be complete before the read that follows it is accepted, so read-after-write returns the new data.

Reset
REQ-037 While wb_rst_n_i is low at a clock edge, the FSM SHALL go to IDLE and the burst counters SHALL clear.
REQ-038 During reset, s_av_readdatavalid_o=0, err_o=0 and s_av_readdata_o=0.
REQ-039 After reset, s_av_waitrequest_o SHALL be 1 if WAIT_CYCLES>0, else 0.
REQ-040 Memory contents SHALL not be cleared by reset, and SHALL be unchanged by a reset that aborts a burst mid-operation.
REQ-041 An aborted read burst SHALL emit no further readdatavalid.

Verification
REQ-042 Write-then-read check (defaults): write 0xDEADBEEF to address 0x10 with byteenable 0xF and burstcount 1, then read 0x10 -> readdatavalid 1 cycle after accept with data 0xDEADBEEF.
REQ-043 Write-burst wrap check: 4-beat write at byte address 0x3F8 (words 254,255,0,1) with data 1..4, then 4-beat read -> data 1,2,3,4 on 4 consecutive valid cycles.
REQ-044 Byte-enable check: word 0x0 holds 0x11223344; write 0xAABBCCDD with byteenable 0b0101 -> readback 0x11BB33DD.
REQ-045 Timing-parameter check: WAIT_CYCLES=3 and READ_LATENCY=4, read with burstcount 2 -> waitrequest high 3 cycles, accept on cycle 4, valid beats 4 and 5 cycles after accept.
REQ-046 Mid-burst reset check: reset asserted mid 8-beat read after beat 3 -> no further readdatavalid and FSM in IDLE; a new read returns the stored data intact.
REQ-047 Error check: read and write high together -> write performed, no readdatavalid, err_o=1 until reset.
